data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (synchronous write, asynchronous read).
- Requester 0 is the core load/store path; requester 1 is the debug/DMA port.
- Grants one access per cycle using round-robin on conflict.
- Registers read data into per-requester response registers.
- Supports locked multi-cycle ownership for read-modify-write, with a timeout.

Parameters:
- DATA_SIZE, 8: data word width; must match the memory.
- ADDR_SIZE, 5: address width; must match the memory.
- LOCK_MAX, 16: maximum consecutive cycles one requester may hold a lock; must be ≥2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active high
- REQ0 / REQ1  in  1  access request, requester 0 / 1
- W0 / W1  in  1  1 = write, 0 = read
- LOCK0 / LOCK1  in  1  keep ownership after this access
- ADDR0 / ADDR1  in  ADDR_SIZE  access address
- DATA_WR0 / DATA_WR1  in  DATA_SIZE  write data
- GNT0 / GNT1  out  1  access accepted this cycle
- RVALID0 / RVALID1  out  1  read data valid, one-cycle pulse
- DATA_RD0 / DATA_RD1  out  DATA_SIZE  registered read data
- MEM_W  out  1  memory write enable
- MEM_ADDR  out  ADDR_SIZE  memory address
- MEM_DATA_WR  out  DATA_SIZE  memory write data
- MEM_DATA_RD  in  DATA_SIZE  memory read data (asynchronous)
- LOCK_TO  out  1  sticky flag: a lock was forcibly released by timeout

Behaviour:
Reset and request rules:
- Clock is clk; reset rst is asynchronous, active high.
- Reset state: FSM = IDLE, last_gnt = 1, lock counter = 0.
- Reset values: RVALIDx = 0, DATA_RDx = 0, LOCK_TO = 0.
- While rst is high: GNTx = 0, MEM_W = 0, MEM_ADDR = 0, MEM_DATA_WR = 0.
- Requester holds REQ/W/LOCK/ADDR/DATA_WR stable until it sees GNT high at a rising edge.
- An access completes on the edge where GNT = 1.

Grant and datapath:
- GNTx is combinational from the current REQ inputs and state.
- At most one GNT is high per cycle.
- The granted requester's W/ADDR/DATA_WR drive MEM_* combinationally.
- MEM_W = GNTx & Wx. When neither GNT is high: MEM_W = 0 and MEM_ADDR/MEM_DATA_WR hold requester 0's values.
- Write latency: data is committed at the grant edge.
- Read latency: at the grant edge, MEM_DATA_RD is captured into DATA_RDx and RVALIDx = 1 for exactly the next cycle.
- DATA_RDx holds its value until the next read by that requester.
- A write grant leaves RVALIDx = 0.

FSM states: IDLE, OWN0, OWN1.
- IDLE, single request: grant that requester.
- IDLE, both requesting: grant the requester != last_gnt.
- last_gnt updates on every grant.
- IDLE to OWNx: on a grant to x with LOCKx = 1; lock counter set to 1.
- OWNx: only x may be granted; the other requester stalls with GNT = 0. Each cycle in OWNx increments the counter.
- OWNx to IDLE, normal release: a granted access with LOCKx = 0, or REQx = 0 in any cycle.
- OWNx to IDLE, forced release: counter reaches LOCK_MAX. That cycle still grants x if REQx; LOCK_TO sets (sticky until rst); last_gnt = x so the other requester wins the next conflict.
- Back-to-back: in IDLE the other requester can be granted on the cycle immediately after release.

Boundary conditions:
- Simultaneous requests with last_gnt = 1 after reset: requester 0 wins first.
- A locked requester issuing reads every cycle gets RVALID every cycle.
- Reset mid-operation: pending RVALID is cleared, ownership dropped, no write occurs during reset.
- Address range covers the full memory; there is no invalid-address path.
- Fairness: a continuously requesting requester is granted within 2 cycles in IDLE, or within LOCK_MAX+1 cycles when the other holds a lock.

Test Plan:
1. After rst, with the memory reset-initialised to mem[i] = i: REQ0 read ADDR0 = 5 -> GNT0 same cycle; next cycle RVALID0 = 1, DATA_RD0 = 0x05; RVALID1 stays 0.
2. REQ1 write ADDR1 = 3, DATA_WR1 = 0xA5, then REQ1 read ADDR1 = 3 -> MEM_W = 1 for one cycle only; read returns DATA_RD1 = 0xA5 one cycle after its grant.
3. REQ0 and REQ1 both held as reads for 4 cycles -> grants alternate 0,1,0,1; each RVALID pulse follows its own grant by one cycle.
4. REQ0 with LOCK0 = 1 for 3 reads then LOCK0 = 0, REQ1 held throughout -> GNT0 on 4 consecutive cycles, GNT1 the cycle after; LOCK_TO stays 0.
5. LOCK0 held high and REQ0 held high, LOCK_MAX = 4, REQ1 high -> GNT0 for 4 cycles, GNT1 on cycle 5, LOCK_TO = 1 and stays 1.
6. rst asserted mid-cycle the cycle after a read grant -> RVALID0 = 0 and GNT0/1 = 0 immediately; state IDLE; first conflict after release grants requester 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory: round-robin on
// conflict, locked ownership for read-modify-write with a forced-release timeout.
module data_mem_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 5,
    parameter int LOCK_MAX  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 REQ0,
    input  logic                 REQ1,
    input  logic                 W0,
    input  logic                 W1,
    input  logic                 LOCK0,
    input  logic                 LOCK1,
    input  logic [ADDR_SIZE-1:0] ADDR0,
    input  logic [ADDR_SIZE-1:0] ADDR1,
    input  logic [DATA_SIZE-1:0] DATA_WR0,
    input  logic [DATA_SIZE-1:0] DATA_WR1,
    output logic                 GNT0,
    output logic                 GNT1,
    output logic                 RVALID0,
    output logic                 RVALID1,
    output logic [DATA_SIZE-1:0] DATA_RD0,
    output logic [DATA_SIZE-1:0] DATA_RD1,
    output logic                 MEM_W,
    output logic [ADDR_SIZE-1:0] MEM_ADDR,
    output logic [DATA_SIZE-1:0] MEM_DATA_WR,
    input  logic [DATA_SIZE-1:0] MEM_DATA_RD,
    output logic                 LOCK_TO
);
    localparam int CW = $clog2(LOCK_MAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 last_gnt_q, last_gnt_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                 lock_to_q, lock_to_d;
    logic                 rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_SIZE-1:0] data_rd0_q, data_rd0_d, data_rd1_q, data_rd1_d;
    logic                 gnt0_raw, gnt1_raw;

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        gnt0_raw   = 1'b0;
        gnt1_raw   = 1'b0;
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        lock_to_d  = lock_to_q;
        case (state_q)
            S_IDLE: begin
                if (REQ0 && REQ1) begin
                    gnt0_raw = last_gnt_q;
                    gnt1_raw = !last_gnt_q;
                end else begin
                    gnt0_raw = REQ0;
                    gnt1_raw = REQ1;
                end
                if (gnt0_raw && LOCK0) begin
                    state_d = S_OWN0;
                    cnt_d   = CW'(1);
                end else if (gnt1_raw && LOCK1) begin
                    state_d = S_OWN1;
                    cnt_d   = CW'(1);
                end
            end
            S_OWN0: begin
                gnt0_raw = REQ0;
                // Normal release wins over the timeout so a clean unlock never flags LOCK_TO.
                if (!REQ0 || !LOCK0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc >= CW'(LOCK_MAX)) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    lock_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_OWN1: begin
                gnt1_raw = REQ1;
                if (!REQ1 || !LOCK1) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc >= CW'(LOCK_MAX)) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    lock_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (gnt0_raw)      last_gnt_d = 1'b0;
        else if (gnt1_raw) last_gnt_d = 1'b1;
    end

    assign GNT0 = gnt0_raw && !rst;
    assign GNT1 = gnt1_raw && !rst;

    assign MEM_W       = (GNT0 && W0) || (GNT1 && W1);
    assign MEM_ADDR    = rst ? '0 : (GNT1 ? ADDR1 : ADDR0);
    assign MEM_DATA_WR = rst ? '0 : (GNT1 ? DATA_WR1 : DATA_WR0);

    always_comb begin
        rvalid0_d  = GNT0 && !W0;
        rvalid1_d  = GNT1 && !W1;
        data_rd0_d = rvalid0_d ? MEM_DATA_RD : data_rd0_q;
        data_rd1_d = rvalid1_d ? MEM_DATA_RD : data_rd1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            lock_to_q  <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            data_rd0_q <= '0;
            data_rd1_q <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            lock_to_q  <= lock_to_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            data_rd0_q <= data_rd0_d;
            data_rd1_q <= data_rd1_d;
        end
    end

    assign RVALID0  = rvalid0_q;
    assign RVALID1  = rvalid1_q;
    assign DATA_RD0 = data_rd0_q;
    assign DATA_RD1 = data_rd1_q;
    assign LOCK_TO  = lock_to_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed plan items, then random traffic
// against an ownership/round-robin reference model and a shadow memory.
module tb_data_mem_arbiter;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int LM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req [2];
    logic          w   [2];
    logic          lk  [2];
    logic [AW-1:0] ad  [2];
    logic [DW-1:0] dt  [2];

    logic          gnt0, gnt1, rv0, rv1, mem_w, lock_to;
    logic [DW-1:0] drd0, drd1, mem_wd, mem_rd;
    logic [AW-1:0] mem_a;

    data_mem_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .REQ0(req[0]), .REQ1(req[1]), .W0(w[0]), .W1(w[1]),
        .LOCK0(lk[0]), .LOCK1(lk[1]), .ADDR0(ad[0]), .ADDR1(ad[1]),
        .DATA_WR0(dt[0]), .DATA_WR1(dt[1]),
        .GNT0(gnt0), .GNT1(gnt1), .RVALID0(rv0), .RVALID1(rv1),
        .DATA_RD0(drd0), .DATA_RD1(drd1),
        .MEM_W(mem_w), .MEM_ADDR(mem_a), .MEM_DATA_WR(mem_wd), .MEM_DATA_RD(mem_rd),
        .LOCK_TO(lock_to)
    );

    // Memory: reset-initialised to mem[i] = i, synchronous write, asynchronous read.
    logic [DW-1:0] mem [1<<AW];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(i);
        end else if (mem_w) begin
            mem[mem_a] <= mem_wd;
        end
    end
    assign mem_rd = mem[mem_a];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_owner;
    int            m_held;
    int            m_last;
    bit            m_lock_to;
    logic [DW-1:0] shadow [1<<AW];
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];

    task automatic model_reset();
        m_owner   = -1;
        m_held    = 0;
        m_last    = 1;
        m_lock_to = 1'b0;
        for (int i = 0; i < (1 << AW); i++) shadow[i] = DW'(i);
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Check one cycle of grant/memory outputs, advance the model, wait to next negedge.
    task automatic cycle(output int g);
        #1;
        if (m_owner < 0) begin
            if (req[0] && req[1]) g = 1 - m_last;
            else if (req[0])      g = 0;
            else if (req[1])      g = 1;
            else                  g = -1;
        end else begin
            g = req[m_owner] ? m_owner : -1;
        end
        chk("gnt", {gnt1, gnt0}, (g == 1) ? 2 : (g == 0) ? 1 : 0);
        chk("mem_w", mem_w, (g >= 0) && w[g]);
        chk("lock_to", lock_to, m_lock_to);
        if (g >= 0) begin
            chk("mem_addr", mem_a, ad[g]);
            if (w[g]) begin
                chk("mem_wdata", mem_wd, dt[g]);
                shadow[ad[g]] = dt[g];
            end else if (g == 0) exp_q0.push_back(shadow[ad[0]]);
            else                 exp_q1.push_back(shadow[ad[1]]);
            m_last = g;
        end
        if (m_owner < 0) begin
            if (g >= 0 && lk[g]) begin
                m_owner = g;
                m_held  = 1;
            end
        end else if (!req[m_owner] || !lk[m_owner]) begin
            m_owner = -1;
        end else begin
            m_held++;
            if (m_held >= LM) begin
                m_last    = m_owner;
                m_owner   = -1;
                m_lock_to = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // Monitor: read responses must appear exactly one cycle after their grant.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("rvalid0", rv0, exp_q0.size() > 0);
            if (exp_q0.size() > 0) begin
                logic [DW-1:0] e0;
                e0 = exp_q0.pop_front();
                if (rv0) chk("data_rd0", drd0, e0);
            end
            chk("rvalid1", rv1, exp_q1.size() > 0);
            if (exp_q1.size() > 0) begin
                logic [DW-1:0] e1;
                e1 = exp_q1.pop_front();
                if (rv1) chk("data_rd1", drd1, e1);
            end
        end
    end

    task automatic set_req(input int r, input logic q, input logic wr, input logic l,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[r] = q; w[r] = wr; lk[r] = l; ad[r] = a; dt[r] = d;
    endtask

    initial begin
        int g;
        for (int r = 0; r < 2; r++) set_req(r, 1'b0, 1'b0, 1'b0, '0, '0);
        model_reset();
        #1;
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_mem_w", mem_w, 0);
        chk("rst_mem_addr", mem_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rvalid", {rv1, rv0}, 0);
        chk("rst_data_rd", {drd1, drd0}, 0);
        @(negedge clk);

        // Plain read from requester 0
        set_req(0, 1, 0, 0, 5'd5, 8'h00);
        cycle(g);
        set_req(0, 0, 0, 0, 5'd0, 8'h00);
        cycle(g);

        // Requester 1 write then read back
        set_req(1, 1, 1, 0, 5'd3, 8'hA5);
        cycle(g);
        set_req(1, 1, 0, 0, 5'd3, 8'h00);
        cycle(g);
        set_req(1, 0, 0, 0, 5'd0, 8'h00);
        cycle(g);

        // Both reading continuously: alternation
        set_req(0, 1, 0, 0, 5'd1, 8'h00);
        set_req(1, 1, 0, 0, 5'd2, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cycle(g);
            if (g >= 0) ad[g] = ad[g] + 5'd4;
        end

        // Three locked reads then an unlocking read, requester 1 held throughout
        set_req(0, 1, 0, 1, 5'd8, 8'h00);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) lk[0] = 1'b0;
            cycle(g);
        end

        // Lock held past LOCK_MAX forces release
        req[0] = 1'b1; lk[0] = 1'b1; req[1] = 1'b1;
        for (int i = 0; i < 6; i++) cycle(g);
        set_req(0, 0, 0, 0, 5'd0, 8'h00);
        set_req(1, 0, 0, 0, 5'd0, 8'h00);
        cycle(g);

        // Reset during the response cycle of a read, with a write pending
        set_req(0, 1, 0, 0, 5'd9, 8'h00);
        cycle(g);
        rst = 1'b1;
        set_req(0, 1, 1, 1, 5'd7, 8'hEE);
        #1;
        chk("midrst_rvalid0", rv0, 0);
        chk("midrst_gnt", {gnt1, gnt0}, 0);
        chk("midrst_mem_w", mem_w, 0);
        chk("midrst_lock_to", lock_to, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        set_req(0, 1, 0, 0, 5'd7, 8'h00);
        set_req(1, 1, 0, 0, 5'd6, 8'h00);
        cycle(g);
        chk("post_rst_first_winner", g, 0);
        cycle(g);

        // Random traffic
        for (int r = 0; r < 2; r++) req[r] = 1'b0;
        for (int i = 0; i < 800; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req[r] && ($urandom_range(3) != 0))
                    set_req(r, 1'b1, $urandom_range(2) == 0, $urandom_range(3) != 0,
                            AW'($urandom), DW'($urandom));
            end
            cycle(g);
            if (g >= 0) req[g] = 1'b0;
        end
        for (int r = 0; r < 2; r++) req[r] = 1'b0;
        cycle(g);
        cycle(g);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
